bp_me_dram_stream_mem: RTL

Behavioural DRAM-side memory that sits directly downstream of the L2 cache slice. It consumes the slice's DRAM command header and dword data streams, and stores or fetches whole blocks in an internal dword array. It returns a DRAM response header, followed by data beats for reads, after a programmable latency. Its purpose is to let the cache slice be simulated and tested without an external DRAM controller.

---
 rtl/bp_me_dram_stream_mem.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bp_me_dram_stream_mem.sv
// rtl/bp_me_dram_stream_mem.sv - behavioural block-granular DRAM model behind the L2 slice
// Consumes a command header plus dword write beats and answers with a header, plus beats for reads, after a fixed delay.
module bp_me_dram_stream_mem
  #(parameter int paddr_width_p   = 40
  , parameter int dword_width_p   = 64
  , parameter int payload_width_p = 8
  , parameter int mem_els_p       = 1024
  , parameter int latency_p       = 4
  , localparam int dram_mem_msg_header_width_lp = 4 + 3 + paddr_width_p + payload_width_p
  )
  (input  logic                                    clk_i
  , input  logic                                    reset_i
  , input  logic [dram_mem_msg_header_width_lp-1:0] mem_cmd_header_i
  , input  logic                                    mem_cmd_header_v_i
  , output logic                                    mem_cmd_header_yumi_o
  , input  logic [dword_width_p-1:0]                mem_cmd_data_i
  , input  logic                                    mem_cmd_data_v_i
  , output logic                                    mem_cmd_data_yumi_o
  , output logic [dram_mem_msg_header_width_lp-1:0] mem_resp_header_o
  , output logic                                    mem_resp_header_v_o
  , input  logic                                    mem_resp_header_ready_i
  , output logic [dword_width_p-1:0]                mem_resp_data_o
  , output logic                                    mem_resp_data_v_o
  , input  logic                                    mem_resp_data_ready_i
  );

  localparam int hdr_w_lp       = dram_mem_msg_header_width_lp;
  localparam int lg_els_lp      = $clog2(mem_els_p);
  localparam int wait_cycles_lp = (latency_p > 0) ? latency_p : 1;
  localparam int lat_width_lp   = $clog2(wait_cycles_lp + 1);

  localparam logic [3:0] e_bedrock_mem_wr    = 4'd1;
  localparam logic [3:0] e_bedrock_mem_uc_wr = 4'd3;

  typedef enum logic [1:0] {e_ready, e_write, e_wait, e_resp} state_e;
  state_e state_r, state_n;

  logic [3:0]               msg_type_r;
  logic [2:0]               size_r;
  logic [paddr_width_p-1:0] addr_r;
  logic [4:0]               beat_r;
  logic [lat_width_lp-1:0]  lat_r;
  logic                     hdr_sent_r;

  logic [4:0]               nbeats;
  logic [lg_els_lp-1:0]     dword_idx, beat_mask, base_idx, idx;
  logic [3:0]               cmd_msg_type;
  logic                     cmd_is_wr, is_wr_r;
  logic                     beat_last, beats_done, lat_done;
  logic                     hdr_fire, data_fire;
  logic                     unused_payload;

  logic [dword_width_p-1:0] mem_r [mem_els_p];

  assign cmd_msg_type   = mem_cmd_header_i[hdr_w_lp-1 -: 4];
  assign cmd_is_wr      = (cmd_msg_type == e_bedrock_mem_wr) || (cmd_msg_type == e_bedrock_mem_uc_wr);
  assign is_wr_r        = (msg_type_r == e_bedrock_mem_wr) || (msg_type_r == e_bedrock_mem_uc_wr);
  assign unused_payload = ^mem_cmd_header_i[payload_width_p-1:0];

  // Sub-dword sizes still move one whole dword beat
  always_comb begin
    case (size_r)
      3'd4:    nbeats = 5'd2;
      3'd5:    nbeats = 5'd4;
      3'd6:    nbeats = 5'd8;
      3'd7:    nbeats = 5'd16;
      default: nbeats = 5'd1;
    endcase
  end

  assign dword_idx = addr_r[3 +: lg_els_lp];
  assign beat_mask = lg_els_lp'(nbeats - 5'd1);
  assign base_idx  = dword_idx & ~beat_mask;
  assign idx       = base_idx + lg_els_lp'(beat_r);

  assign beat_last  = (beat_r == nbeats - 5'd1);
  assign beats_done = (beat_r == nbeats);
  assign lat_done   = (lat_r == lat_width_lp'(wait_cycles_lp - 1));
  assign hdr_fire   = (state_r == e_resp) && !hdr_sent_r && mem_resp_header_ready_i;
  assign data_fire  = (state_r == e_resp) && !is_wr_r && !beats_done && mem_resp_data_ready_i;

  assign mem_resp_header_o = {msg_type_r, size_r, addr_r, {payload_width_p{1'b0}}};
  assign mem_resp_data_o   = mem_r[idx];

  always_comb begin
    state_n               = state_r;
    mem_cmd_header_yumi_o = 1'b0;
    mem_cmd_data_yumi_o   = 1'b0;
    mem_resp_header_v_o   = 1'b0;
    mem_resp_data_v_o     = 1'b0;
    case (state_r)
      e_ready: begin
        mem_cmd_header_yumi_o = mem_cmd_header_v_i;
        if (mem_cmd_header_v_i)
          state_n = cmd_is_wr ? e_write : e_wait;
      end
      e_write: begin
        mem_cmd_data_yumi_o = mem_cmd_data_v_i;
        if (mem_cmd_data_v_i && beat_last)
          state_n = e_wait;
      end
      e_wait: begin
        if (lat_done)
          state_n = e_resp;
      end
      e_resp: begin
        mem_resp_header_v_o = !hdr_sent_r;
        mem_resp_data_v_o   = !is_wr_r && !beats_done;
        // Header and data channels finish independently; leave when both are through
        if ((hdr_sent_r || hdr_fire) && (is_wr_r || beats_done || (data_fire && beat_last)))
          state_n = e_ready;
      end
      default: state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_ready;
      beat_r     <= '0;
      lat_r      <= '0;
      hdr_sent_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (mem_cmd_header_yumi_o) begin
        beat_r     <= '0;
        lat_r      <= '0;
        hdr_sent_r <= 1'b0;
      end
      if (mem_cmd_data_yumi_o)
        beat_r <= beat_last ? 5'd0 : beat_r + 5'd1;
      if (state_r == e_wait)
        lat_r <= lat_r + 1'b1;
      if (hdr_fire)
        hdr_sent_r <= 1'b1;
      if (data_fire)
        beat_r <= beat_r + 5'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_cmd_header_yumi_o) begin
      msg_type_r <= cmd_msg_type;
      size_r     <= mem_cmd_header_i[hdr_w_lp-5 -: 3];
      addr_r     <= mem_cmd_header_i[payload_width_p +: paddr_width_p];
    end
  end

  // Storage is deliberately never reset; beats accepted before a reset survive it
  always_ff @(posedge clk_i) begin
    if (mem_cmd_data_yumi_o && !reset_i)
      mem_r[idx] <= mem_cmd_data_i;
  end

endmodule
